// File: rtl/prf_multiport.sv
// Multi-ported physical register file with per-entry operand-ready bits,
// an INIT sweep after reset, optional write-to-read bypass and conflict counting.
module prf_multiport #(
    parameter int PRF_NUM = 64,
    parameter int XLEN    = 32,
    parameter int N_RD    = 6,
    parameter int N_WR    = 4,
    parameter int N_ALLOC = 2,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(PRF_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_RD*AW-1:0]     rd_addr,
    output logic [N_RD*XLEN-1:0]   rd_data,
    output logic [N_RD-1:0]        rd_ready,
    input  logic [N_WR-1:0]        wr_valid,
    input  logic [N_WR*AW-1:0]     wr_addr,
    input  logic [N_WR*XLEN-1:0]   wr_data,
    input  logic [N_ALLOC-1:0]     alloc_valid,
    input  logic [N_ALLOC*AW-1:0]  alloc_addr,
    output logic                   init_done,
    output logic                   wr_conflict,
    output logic [15:0]            conflict_cnt
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             r_state;
    logic [AW-1:0]      r_init_ptr;
    logic [XLEN-1:0]    r_mem [PRF_NUM];
    logic [PRF_NUM-1:0] r_ready;
    logic               r_init_done;
    logic               r_wr_conflict;
    logic [15:0]        r_conflict_cnt;

    logic [N_WR-1:0]    w_wr_en;
    logic [N_ALLOC-1:0] w_alloc_en;
    logic               w_conflict;

    // Writes and allocs only take effect in RUN and never touch entry 0.
    always_comb begin
        w_wr_en    = '0;
        w_alloc_en = '0;
        for (int j = 0; j < N_WR; j++)
            w_wr_en[j] = wr_valid[j] && (wr_addr[j*AW +: AW] != '0) && (r_state == ST_RUN);
        for (int i = 0; i < N_ALLOC; i++)
            w_alloc_en[i] = alloc_valid[i] && (alloc_addr[i*AW +: AW] != '0) && (r_state == ST_RUN);
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < N_WR; j++)
            for (int k = j + 1; k < N_WR; k++)
                if (w_wr_en[j] && w_wr_en[k] && (wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW]))
                    w_conflict = 1'b1;
    end

    // Ascending port order makes the highest-index writer win on the array and the bypass.
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        for (int k = 0; k < N_RD; k++) begin
            if (r_state == ST_RUN) begin
                if (rd_addr[k*AW +: AW] == '0) begin
                    rd_ready[k] = 1'b1;
                end else begin
                    rd_data[k*XLEN +: XLEN] = r_mem[rd_addr[k*AW +: AW]];
                    rd_ready[k]             = r_ready[rd_addr[k*AW +: AW]];
                    if (BYPASS != 0) begin
                        for (int j = 0; j < N_WR; j++) begin
                            if (w_wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])) begin
                                rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                                rd_ready[k]             = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // The data array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_init_ptr] <= '0;
        end else if (!rst) begin
            for (int j = 0; j < N_WR; j++)
                if (w_wr_en[j])
                    r_mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_INIT;
            r_init_ptr     <= '0;
            r_init_done    <= 1'b0;
            r_wr_conflict  <= 1'b0;
            r_conflict_cnt <= '0;
            r_ready        <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ready[r_init_ptr] <= 1'b1;
                    r_init_ptr          <= r_init_ptr + 1'b1;
                    r_wr_conflict       <= 1'b0;
                    if (r_init_ptr == AW'(PRF_NUM - 1)) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    for (int j = 0; j < N_WR; j++)
                        if (w_wr_en[j])
                            r_ready[wr_addr[j*AW +: AW]] <= 1'b1;
                    // Allocation is applied last so it overrides a same-cycle writeback.
                    for (int i = 0; i < N_ALLOC; i++)
                        if (w_alloc_en[i])
                            r_ready[alloc_addr[i*AW +: AW]] <= 1'b0;
                    r_wr_conflict <= w_conflict;
                    if (w_conflict && (r_conflict_cnt != 16'hFFFF))
                        r_conflict_cnt <= r_conflict_cnt + 16'd1;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign init_done    = r_init_done;
    assign wr_conflict  = r_wr_conflict;
    assign conflict_cnt = r_conflict_cnt;

endmodule
